l2bus_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared L2 coherence bus. Grants the bus to one of `NREQ` bus agents (L2 transmitters, memory controller, I/O bridge) per transaction and holds the grant for the full beat count implied by the command. It publishes the bus framing signals `bus_valid`, `bus_beat` and `bus_last`. It terminates a transaction early on `bus_nack`. Sits beside the bus OR-mux; agents drive bus fields only while their grant bit is high.

---
 rtl/l2bus_pkg.sv | 22 ++
 rtl/rr_pick.sv | 21 ++
 rtl/l2bus_arbiter.sv | 75 +++++++
 tb/tb_l2bus_arbiter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/l2bus_pkg.sv
// l2bus_pkg: shared L2 coherence bus command encodings, widths and FSM states
package l2bus_pkg;
    localparam int L2BUS_BEATW  = 3;
    localparam int CMD_DATA_BIT = 2;
    localparam int L2BUS_TAGW   = 8;
    localparam int L2BUS_ADDRW  = 40;

    typedef enum logic [2:0] {
        CMD_NOP       = 3'd0,
        CMD_READ      = 3'd1,
        CMD_RWITM     = 3'd2,
        CMD_INVAL     = 3'd3,
        CMD_WRITEBACK = 3'd4,
        CMD_RDATA     = 3'd5
    } cmd_t;

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    function automatic logic cmd_is_data(input logic [2:0] c);
        return c[CMD_DATA_BIT];
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, search starts at ptr and wraps
module rr_pick import l2bus_pkg::*; #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[(k + int'(ptr)) % N]) begin
                gnt[(k + int'(ptr)) % N] = 1'b1;
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/l2bus_arbiter.sv
// l2bus_arbiter: round-robin L2 bus arbiter holding each grant for its command's beat count
module l2bus_arbiter import l2bus_pkg::*; #(
    parameter int NREQ  = 4,
    parameter int BEATW = L2BUS_BEATW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*3-1:0] req_cmd,
    input  logic              bus_nack,
    output logic [NREQ-1:0]   grant,
    output logic              bus_valid,
    output logic [BEATW-1:0]  bus_beat,
    output logic              bus_last,
    output logic              busy
);
    localparam int PW = $clog2(NREQ);

    state_t            st, st_n;
    logic [NREQ-1:0]   grant_n, pick;
    logic              pick_v, win_data, xfer_end, arb;
    logic [BEATW-1:0]  beat, beat_n, len_m1, len_m1_n;
    logic [PW-1:0]     ptr, ptr_n, win_idx;

    rr_pick #(.N(NREQ), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .gnt   (pick),
        .valid (pick_v)
    );

    always_comb begin
        win_idx  = '0;
        win_data = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                win_idx  = PW'(i);
                win_data = cmd_is_data(req_cmd[3*i +: 3]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st     <= ST_IDLE;
            grant  <= '0;
            beat   <= '0;
            len_m1 <= '0;
            ptr    <= '0;
        end else begin
            st     <= st_n;
            grant  <= grant_n;
            beat   <= beat_n;
            len_m1 <= len_m1_n;
            ptr    <= ptr_n;
        end
    end

    always_comb begin
        xfer_end = (st == ST_XFER) && ((beat == len_m1) || bus_nack);
        arb      = (st == ST_IDLE) || xfer_end;
        st_n     = arb ? (pick_v ? ST_XFER : ST_IDLE) : st;
        grant_n  = arb ? pick : grant;
        beat_n   = (arb || st != ST_XFER) ? '0 : beat + 1'b1;
        len_m1_n = arb ? ((pick_v && win_data) ? '1 : '0) : len_m1;
        ptr_n    = (arb && pick_v) ? ((win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1) : ptr;
    end

    always_comb begin
        bus_valid = |grant;
        bus_beat  = beat;
        bus_last  = (st == ST_XFER) && (beat == len_m1);
        busy      = (st == ST_XFER);
    end
endmodule

// File: tb/tb_l2bus_arbiter.sv
// tb_l2bus_arbiter: directed scoreboard bench for the L2 bus round-robin arbiter
module tb_l2bus_arbiter;
    import l2bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [11:0] req_cmd = '0;
    logic        bus_nack = 1'b0;
    logic [3:0]  grant;
    logic        bus_valid;
    logic [2:0]  bus_beat;
    logic        bus_last;
    logic        busy;

    typedef struct packed {
        logic [3:0] g;
        logic       v;
        logic [2:0] b;
        logic       l;
        logic       bsy;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   failures = 0;

    l2bus_arbiter #(.NREQ(4), .BEATW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_cmd   (req_cmd),
        .bus_nack  (bus_nack),
        .grant     (grant),
        .bus_valid (bus_valid),
        .bus_beat  (bus_beat),
        .bus_last  (bus_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic [2:0] c);
        req_cmd[3*i +: 3] = c;
    endtask

    task automatic cyc(input logic [3:0] eg, input logic [2:0] eb, input logic el, input string tag);
        obs_t e, o;
        sb.push_back('{g: eg, v: |eg, b: eb, l: el, bsy: |eg});
        step();
        e = sb.pop_front();
        o = '{g: grant, v: bus_valid, b: bus_beat, l: bus_last, bsy: busy};
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s obs=%h exp=%h", tag, o, e);
        end
    endtask

    task automatic chk_ptr(input logic [1:0] p, input string tag);
        checks++;
        assert (dut.ptr === p) else begin
            failures++;
            $error("FAIL %s obs=%0d exp=%0d", tag, dut.ptr, p);
        end
    endtask

    initial begin
        logic [3:0] rot [6];
        rot = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        step();
        cyc(4'b0000, 3'd0, 1'b0, "reset");
        chk_ptr(2'd0, "reset_ptr");
        rst = 1'b1;
        // single READ from agent 0
        set_cmd(0, CMD_READ);
        req = 4'b0001;
        cyc(4'b0001, 3'd0, 1'b1, "read_grant");
        chk_ptr(2'd1, "read_ptr");
        req = 4'b0000;
        cyc(4'b0000, 3'd0, 1'b0, "read_idle");
        // 8-beat WRITEBACK from agent 1
        set_cmd(1, CMD_WRITEBACK);
        req = 4'b0010;
        cyc(4'b0010, 3'd0, 1'b0, "wb_beat0");
        req = 4'b0000;
        for (int b = 1; b < 8; b++)
            cyc(4'b0010, 3'(b), b == 7, $sformatf("wb_beat%0d", b));
        cyc(4'b0000, 3'd0, 1'b0, "wb_idle");
        chk_ptr(2'd2, "wb_ptr");
        // all agents READ, rotation from ptr=2 with no gaps
        for (int i = 0; i < 4; i++) set_cmd(i, CMD_READ);
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            cyc(rot[i], 3'd0, 1'b1, $sformatf("rot%0d", i));
            if (i == 5) req = 4'b0000;
        end
        cyc(4'b0000, 3'd0, 1'b0, "rot_idle");
        chk_ptr(2'd0, "rot_ptr");
        // agent 0 RDATA nacked on beat 2, agent 2 served before retry
        set_cmd(0, CMD_RDATA);
        set_cmd(2, CMD_READ);
        req = 4'b0101;
        cyc(4'b0001, 3'd0, 1'b0, "nack_beat0");
        cyc(4'b0001, 3'd1, 1'b0, "nack_beat1");
        cyc(4'b0001, 3'd2, 1'b0, "nack_beat2");
        bus_nack = 1'b1;
        cyc(4'b0100, 3'd0, 1'b1, "nack_next_agent2");
        chk_ptr(2'd3, "nack_ptr");
        bus_nack = 1'b0;
        req = 4'b0001;
        cyc(4'b0001, 3'd0, 1'b0, "retry_beat0");
        req = 4'b0000;
        for (int b = 1; b < 8; b++)
            cyc(4'b0001, 3'(b), b == 7, $sformatf("retry_beat%0d", b));
        cyc(4'b0000, 3'd0, 1'b0, "retry_idle");
        chk_ptr(2'd1, "retry_ptr");
        // reset during beat 4
        set_cmd(1, CMD_WRITEBACK);
        req = 4'b0010;
        cyc(4'b0010, 3'd0, 1'b0, "rst_beat0");
        req = 4'b0000;
        for (int b = 1; b < 5; b++)
            cyc(4'b0010, 3'(b), 1'b0, $sformatf("rst_beat%0d", b));
        rst = 1'b0;
        cyc(4'b0000, 3'd0, 1'b0, "midrst_out");
        chk_ptr(2'd0, "midrst_ptr");
        rst = 1'b1;
        set_cmd(1, CMD_READ);
        set_cmd(3, CMD_READ);
        req = 4'b1010;
        cyc(4'b0010, 3'd0, 1'b1, "postrst_grant");
        req = 4'b0000;
        cyc(4'b0000, 3'd0, 1'b0, "postrst_idle");
        chk_ptr(2'd2, "postrst_ptr");
        // agent 1 drops req at beat 3, burst runs to completion
        set_cmd(1, CMD_WRITEBACK);
        req = 4'b0010;
        for (int b = 0; b < 8; b++) begin
            cyc(4'b0010, 3'(b), b == 7, $sformatf("drop_beat%0d", b));
            if (b == 3) req = 4'b0000;
        end
        cyc(4'b0000, 3'd0, 1'b0, "drop_idle");
        // single requester streaming back-to-back
        set_cmd(0, CMD_READ);
        req = 4'b0001;
        for (int i = 0; i < 3; i++)
            cyc(4'b0001, 3'd0, 1'b1, $sformatf("stream%0d", i));
        req = 4'b0000;
        cyc(4'b0000, 3'd0, 1'b0, "stream_idle");
        chk_ptr(2'd1, "stream_ptr");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
